// File: rtl/bus_slave_mem_pkg.sv
// Shared bus constants and responder FSM encoding for bus_slave_mem.
package bus_slave_mem_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned WORD_DATA_W = 32;

    typedef enum logic [1:0] {
        BUS_SLV_IDLE = 2'd0,
        BUS_SLV_WAIT = 2'd1,
        BUS_SLV_ACK  = 2'd2
    } bus_slv_state_e;

endpackage

// File: rtl/bus_slv_ram.sv
// Single-port synchronous word RAM; rdata is registered and forced to zero when re is low.
module bus_slv_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        // Zeroing here keeps the bus output clean outside read acknowledges.
        rdata <= re ? mem[addr] : '0;
    end

endmodule

// File: rtl/bus_slave_mem.sv
// Bus responder with programmable wait states backed by bus_slv_ram.
// Optional BUS_SLAVE_MEM_RANGE_CHK_EN adds an err output for out-of-range addresses.
module bus_slave_mem
    import bus_slave_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = WORD_ADDR_W,
    parameter int unsigned DATA_W     = WORD_DATA_W,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WAIT_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_
`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
    ,
    output logic              err
`endif
);

    bus_slv_state_e        state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic                  rw_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  oor_q;

    logic                  req;
    logic                  abort;
    logic                  oor_in;
    logic                  go_ack;
    logic                  go_rw;
    logic                  go_oor;
    logic                  ram_we;
    logic                  ram_re;
    logic [DEPTH_LOG2-1:0] ram_addr;

    assign req   = (cs_ == ENABLE_) && (as_ == ENABLE_);
    assign abort = (cs_ == DISABLE_) || (as_ == DISABLE_);

`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
    assign oor_in = |(addr >> DEPTH_LOG2);
`else
    logic unused_addr_hi;
    assign oor_in         = 1'b0;
    assign unused_addr_hi = |(addr >> DEPTH_LOG2);
`endif

    // The read must be launched on the edge that enters ACK so rd_data lands in the ACK cycle.
    always_comb begin
        go_ack   = 1'b0;
        go_rw    = rw_q;
        go_oor   = oor_q;
        ram_addr = addr_q;
        case (state)
            BUS_SLV_IDLE: begin
                go_ack   = req && (WAIT_CYC == 0);
                go_rw    = rw;
                go_oor   = oor_in;
                ram_addr = addr[DEPTH_LOG2-1:0];
            end
            BUS_SLV_WAIT: go_ack = !abort && (cnt == 4'd0);
            default: ;
        endcase
        ram_re = !reset && go_ack && (go_rw == READ) && !go_oor;
        ram_we = !reset && (state == BUS_SLV_ACK) && (rw_q == WRITE) && !oor_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BUS_SLV_IDLE;
            cnt     <= 4'd0;
            rdy_    <= 1'b1;
            addr_q  <= '0;
            rw_q    <= READ;
            wdata_q <= '0;
            oor_q   <= 1'b0;
`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
            err     <= 1'b0;
`endif
        end else begin
            rdy_ <= !go_ack;
`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
            err  <= go_ack && go_oor;
`endif
            case (state)
                BUS_SLV_IDLE: begin
                    if (req) begin
                        addr_q  <= addr[DEPTH_LOG2-1:0];
                        rw_q    <= rw;
                        wdata_q <= wr_data;
                        oor_q   <= oor_in;
                        if (WAIT_CYC == 0) begin
                            state <= BUS_SLV_ACK;
                        end else begin
                            state <= BUS_SLV_WAIT;
                            cnt   <= 4'(WAIT_CYC - 1);
                        end
                    end
                end
                BUS_SLV_WAIT: begin
                    if (abort) begin
                        state <= BUS_SLV_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= BUS_SLV_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                BUS_SLV_ACK: state <= BUS_SLV_IDLE;
                default:     state <= BUS_SLV_IDLE;
            endcase
        end
    end

    bus_slv_ram #(
        .ADDR_W(DEPTH_LOG2),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(wdata_q),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: two instances (0 and 3 wait states) on one shared bus,
// each checked every cycle against a transaction-timeline model of the responder.
module tb_bus_slave_mem;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int DL = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs_;
    logic          as_;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          rdy0_, rdy1_;
    logic          err0, err1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bus_slave_mem #(.WAIT_CYC(0)) u_dut0 (
        .clk    (clk),
        .reset  (reset),
        .cs_    (cs_),
        .as_    (as_),
        .rw     (rw),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data0),
        .rdy_   (rdy0_)
`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
        ,
        .err    (err0)
`endif
    );

    bus_slave_mem #(.WAIT_CYC(3)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .cs_    (cs_),
        .as_    (as_),
        .rw     (rw),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data1),
        .rdy_   (rdy1_)
`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
        ,
        .err    (err1)
`endif
    );

`ifndef BUS_SLAVE_MEM_RANGE_CHK_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    function automatic int wcyc(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic bit oor(input logic [AW-1:0] a);
`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
        return (a >> DL) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] pre(input int a);
        return 32'hC0DE_0000 + a;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: each transfer is a timeline. Captured at edge c, acknowledged at edge c+W,
    // retired (write committed) at edge c+W+1; any deselect sampled at edges c+1..c+W aborts it.
    bit            busy  [2];
    longint        cap_e [2];
    longint        ack_e [2];
    logic [AW-1:0] t_addr[2];
    bit            t_rw  [2];
    logic [DW-1:0] t_data[2];
    logic [DW-1:0] mm    [2][1024];
    bit            kn    [2][1024];
    bit            e_rdy [2];
    bit            e_err [2];
    logic [DW-1:0] e_rd  [2];
    bit            e_rdk [2];
    longint        edge_n = 0;

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            bit was;
            was = busy[i];
            if (reset) begin
                busy[i] = 1'b0;
            end else if (was) begin
                if (edge_n == ack_e[i] + 1) begin
                    if (!t_rw[i] && !oor(t_addr[i])) begin
                        mm[i][t_addr[i][DL-1:0]] = t_data[i];
                        kn[i][t_addr[i][DL-1:0]] = 1'b1;
                    end
                    busy[i] = 1'b0;
                end else if (edge_n > cap_e[i] && edge_n <= ack_e[i] && (as_ || cs_)) begin
                    busy[i] = 1'b0;
                end
            end else if (!as_ && !cs_) begin
                busy[i]   = 1'b1;
                cap_e[i]  = edge_n;
                ack_e[i]  = edge_n + wcyc(i);
                t_addr[i] = addr;
                t_rw[i]   = rw;
                t_data[i] = wr_data;
            end
            e_rdy[i] = !(busy[i] && edge_n == ack_e[i]);
            e_err[i] = busy[i] && edge_n == ack_e[i] && oor(t_addr[i]);
            e_rd[i]  = '0;
            e_rdk[i] = 1'b1;
            if (busy[i] && edge_n == ack_e[i] && t_rw[i] && !oor(t_addr[i])) begin
                e_rd[i]  = mm[i][t_addr[i][DL-1:0]];
                e_rdk[i] = kn[i][t_addr[i][DL-1:0]];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rdy_[w%0d]", wcyc(i)), (i == 0) ? rdy0_ : rdy1_, e_rdy[i]);
                if (e_rdk[i])
                    chk($sformatf("rd_data[w%0d]", wcyc(i)), (i == 0) ? rd_data0 : rd_data1, e_rd[i]);
`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
                chk($sformatf("err[w%0d]", wcyc(i)), (i == 0) ? err0 : err1, e_err[i]);
`endif
            end
        end
    end

    task automatic idle_bus();
        as_ = 1'b1;
        cs_ = 1'b1;
    endtask

    task automatic hold_req(input bit r, input int a, input logic [DW-1:0] d, input int n);
        @(negedge clk);
        as_ = 1'b0; cs_ = 1'b0; rw = r; addr = AW'(a); wr_data = d;
        repeat (n) @(negedge clk);
        idle_bus();
    endtask

    // One transfer timed on the 3-wait instance; lat = negedges until rdy_ low, -1 on timeout.
    task automatic xfer1(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output logic e, output int lat);
        @(negedge clk);
        as_ = 1'b0; cs_ = 1'b0; rw = r; addr = a; wr_data = d;
        lat = -1; rd = 'x; e = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rdy1_ == 1'b0) begin
                lat = k; rd = rd_data1; e = err1;
                break;
            end
        end
        idle_bus();
    endtask

    logic [DW-1:0] rd;
    logic          e;
    int            lat;

    initial begin
        reset = 1'b1; idle_bus(); rw = 1'b1; addr = '0; wr_data = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset rdy_", rdy1_, 1'b1);
        chk("reset rd_data", rd_data0, '0);
        reset = 1'b0;

        for (int a = 0; a < 34; a++) hold_req(1'b0, a, pre(a), 5);

        // Reset in the second cycle of a 3-wait write.
        @(negedge clk);
        as_ = 1'b0; cs_ = 1'b0; rw = 1'b0; addr = 30'h010; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; idle_bus();
        repeat (4) begin
            @(negedge clk);
            chk("reset-abort rdy_", rdy1_, 1'b1);
        end
        xfer1(1'b1, 30'h010, '0, rd, e, lat);
        chk("reset-abort read 0x010", rd, pre(16));

        // Basic write then read.
        xfer1(1'b0, 30'h005, 32'h1234_5678, rd, e, lat);
        chk("write latency", lat, 4);
        chk("write rd_data", rd, '0);
        xfer1(1'b1, 30'h005, '0, rd, e, lat);
        chk("read latency", lat, 4);
        chk("read-after-write", rd, 32'h1234_5678);

        // Zero-wait back-to-back reads with the strobe held.
        @(negedge clk);
        as_ = 1'b0; cs_ = 1'b0; rw = 1'b1; addr = 30'h000;
        @(negedge clk);
        chk("b2b rdy_ #1", rdy0_, 1'b0);
        chk("b2b data #1", rd_data0, pre(0));
        addr = 30'h001;
        @(negedge clk);
        chk("b2b gap rdy_", rdy0_, 1'b1);
        chk("b2b gap data", rd_data0, '0);
        @(negedge clk);
        chk("b2b rdy_ #2", rdy0_, 1'b0);
        chk("b2b data #2", rd_data0, pre(1));
        idle_bus();

        // Abort a 4-cycle write window after two cycles.
        @(negedge clk);
        as_ = 1'b0; cs_ = 1'b0; rw = 1'b0; addr = 30'h020; wr_data = 32'hAAAA_5555;
        repeat (2) @(negedge clk);
        as_ = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("abort rdy_", rdy1_, 1'b1);
        end
        cs_ = 1'b1;
        xfer1(1'b1, 30'h020, '0, rd, e, lat);
        chk("abort read 0x020", rd, pre(32));

        // Strobe without chip select.
        @(negedge clk);
        as_ = 1'b0; cs_ = 1'b1; rw = 1'b0; addr = 30'h003; wr_data = 32'h0BAD_0BAD;
        repeat (10) begin
            @(negedge clk);
            chk("desel rdy_", rdy0_ & rdy1_, 1'b1);
            chk("desel rd_data", rd_data0 | rd_data1, '0);
        end
        idle_bus();
        xfer1(1'b1, 30'h003, '0, rd, e, lat);
        chk("desel read 0x003", rd, pre(3));

        // Address above the memory depth.
        xfer1(1'b1, 30'h400, '0, rd, e, lat);
        chk("range latency", lat, 4);
`ifdef BUS_SLAVE_MEM_RANGE_CHK_EN
        chk("range err", e, 1'b1);
        chk("range rd_data", rd, '0);
`else
        chk("wrap rd_data", rd, pre(0));
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 99) == 0);
            as_     = ($urandom_range(0, 9) < 2);
            cs_     = ($urandom_range(0, 19) < 3);
            rw      = 1'($urandom_range(0, 1));
            addr    = AW'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) addr[AW-1:DL] = (AW-DL)'($urandom_range(1, 1023));
            wr_data = $urandom();
        end
        @(negedge clk);
        reset = 1'b0; idle_bus();
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
